// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, default timing and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    BITS,
    ACK,
    RELEASE
  } ps2_tx_state_t;

  localparam int unsigned INHIBIT_CYCLES_DEF = 2500;
  localparam int unsigned FIRST_TIMEOUT_DEF  = 375000;
  localparam int unsigned EDGE_TIMEOUT_DEF   = 50000;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_sync.sv
// Two-flop synchronizer for the PS/2 clock/data pins plus device-clock falling-edge detect.
module ps2_sync (
  input  logic clock,
  input  logic reset,
  input  logic ps_clk_i,
  input  logic ps_dat_i,
  output logic clk_s,
  output logic dat_s,
  output logic fall
);

  logic [1:0] clk_q;
  logic [1:0] dat_q;
  logic       clk_prev;

  always_ff @(posedge clock) begin
    if (reset) begin
      clk_q    <= '1;
      dat_q    <= '1;
      clk_prev <= 1'b1;
    end else begin
      clk_q    <= {clk_q[0], ps_clk_i};
      dat_q    <= {dat_q[0], ps_dat_i};
      clk_prev <= clk_q[1];
    end
  end

  assign clk_s = clk_q[1];
  assign dat_s = dat_q[1];
  assign fall  = clk_prev & ~clk_q[1];

endmodule

// File: rtl/ps2_tx.sv
// Host-to-device PS/2 command transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
module ps2_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int unsigned FIRST_TIMEOUT  = FIRST_TIMEOUT_DEF,
  parameter int unsigned EDGE_TIMEOUT   = EDGE_TIMEOUT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  input  logic       ps_clk_i,
  input  logic       ps_dat_i,
  output logic       ps_clk_oe,
  output logic       ps_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  localparam logic [18:0] INH_LOAD   = 19'(INHIBIT_CYCLES - 1);
  localparam logic [18:0] FIRST_LOAD = 19'(FIRST_TIMEOUT);
  localparam logic [18:0] EDGE_LOAD  = 19'(EDGE_TIMEOUT);

  ps2_tx_state_t state;
  logic [18:0]   cnt;
  logic [3:0]    bitcnt;
  logic [9:0]    sh;
  logic          clk_s;
  logic          dat_s;
  logic          fall;

  ps2_sync u_sync (
    .clock    (clock),
    .reset    (reset),
    .ps_clk_i (ps_clk_i),
    .ps_dat_i (ps_dat_i),
    .clk_s    (clk_s),
    .dat_s    (dat_s),
    .fall     (fall)
  );

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      bitcnt    <= '0;
      sh        <= '0;
      ps_clk_oe <= 1'b0;
      ps_dat_oe <= 1'b0;
      done      <= 1'b0;
      ack_ok    <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          ps_clk_oe <= 1'b0;
          ps_dat_oe <= 1'b0;
          if (start) begin
            sh        <= {1'b1, odd_parity(data), data};
            ack_ok    <= 1'b0;
            error     <= 1'b0;
            cnt       <= INH_LOAD;
            bitcnt    <= '0;
            ps_clk_oe <= 1'b1;
            state     <= INHIBIT;
          end
        end
        INHIBIT: begin
          // Start bit goes low one cycle before the clock is released.
          if (cnt == '0) begin
            ps_clk_oe <= 1'b0;
            ps_dat_oe <= 1'b1;
            cnt       <= FIRST_LOAD;
            state     <= REQ;
          end else begin
            if (cnt == 19'd1) ps_dat_oe <= 1'b1;
            cnt <= cnt - 19'd1;
          end
        end
        REQ, BITS: begin
          if (fall) begin
            ps_dat_oe <= ~sh[0];
            sh        <= {1'b0, sh[9:1]};
            bitcnt    <= (state == REQ) ? 4'd1 : bitcnt + 4'd1;
            cnt       <= EDGE_LOAD;
            if (state == REQ) state <= BITS;
            else if (bitcnt == 4'd9) state <= ACK;
          end else if (cnt == '0) begin
            ps_clk_oe <= 1'b0;
            ps_dat_oe <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 19'd1;
          end
        end
        ACK: begin
          ps_dat_oe <= 1'b0;
          if (fall) begin
            if (dat_s) error  <= 1'b1;
            else       ack_ok <= 1'b1;
            cnt   <= EDGE_LOAD;
            state <= RELEASE;
          end else if (cnt == '0) begin
            ps_clk_oe <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 19'd1;
          end
        end
        RELEASE: begin
          ps_dat_oe <= 1'b0;
          if (clk_s && dat_s) begin
            done  <= 1'b1;
            state <= IDLE;
          end else if (cnt == '0) begin
            ps_clk_oe <= 1'b0;
            error     <= 1'b1;
            done      <= 1'b1;
            state     <= IDLE;
          end else begin
            cnt <= cnt - 19'd1;
          end
        end
        default: begin
          ps_clk_oe <= 1'b0;
          ps_dat_oe <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_tx.sv
// Bench for ps2_tx: open-drain line model with a behavioural PS/2 device and frame reference.
module tb_ps2_tx;

  localparam int unsigned INH  = 2500;
  localparam int unsigned FTO  = 3000;
  localparam int unsigned ETO  = 1000;
  localparam int unsigned HALF = 30;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data  = '0;
  logic       dev_clk = 1'b1;
  logic       dev_dat = 1'b1;
  logic       ps_clk_i, ps_dat_i;
  logic       ps_clk_oe, ps_dat_oe, busy, done, ack_ok, error;

  assign ps_clk_i = dev_clk & ~ps_clk_oe;
  assign ps_dat_i = dev_dat & ~ps_dat_oe;

  ps2_tx #(
    .INHIBIT_CYCLES (INH),
    .FIRST_TIMEOUT  (FTO),
    .EDGE_TIMEOUT   (ETO)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .data      (data),
    .ps_clk_i  (ps_clk_i),
    .ps_dat_i  (ps_dat_i),
    .ps_clk_oe (ps_clk_oe),
    .ps_dat_oe (ps_dat_oe),
    .busy      (busy),
    .done      (done),
    .ack_ok    (ack_ok),
    .error     (error)
  );

  always #20 clock = ~clock;

  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned cyc = 0;
  int          done_cnt = 0;
  int unsigned done_cyc = 0;
  logic        done_ack, done_err, done_busy, done_clk_oe, done_dat_oe;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (done) begin
      done_cnt    = done_cnt + 1;
      done_cyc    = cyc;
      done_ack    = ack_ok;
      done_err    = error;
      done_busy   = busy;
      done_clk_oe = ps_clk_oe;
      done_dat_oe = ps_dat_oe;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame as the device sees it: D0..D7, odd parity, stop.
  function automatic logic frame_bit(input logic [7:0] d, input int i);
    if (i < 8) return d[i];
    if (i == 8) return ($countones(d) % 2) == 0;
    return 1'b1;
  endfunction

  task automatic wait_done(input int base, input int lim);
    int t = 0;
    while (done_cnt == base && t < lim) begin
      @(negedge clock);
      t++;
    end
    check("done_seen", 32'(done_cnt > base), 1);
    repeat (3) @(negedge clock);
    check("single_done", done_cnt, base + 1);
  endtask

  // mode: 0 ack, 1 nack, 2 silent device, 3 device stops after 5 edges,
  //       4 start pulse mid-frame, 5 reset mid-frame
  task automatic run_xfer(input logic [7:0] d, input int mode);
    logic [9:0]  got_bits;
    int          hi, base, nclk;
    logic        dl, dpl;
    int unsigned rel_cyc, fall_cyc, dly;
    base     = done_cnt;
    got_bits = '0;
    fall_cyc = 0;
    @(negedge clock);
    data  = d;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    data  = 8'($urandom);
    check("busy_after_start", busy, 1);
    hi = 0; dl = 1'b0; dpl = 1'b0;
    while (ps_clk_oe === 1'b1 && hi < int'(INH) + 100) begin
      dpl = dl;
      dl  = ps_dat_oe;
      hi++;
      @(negedge clock);
    end
    check("inhibit_len", hi, INH);
    check("dat_oe_rise_last", dl, 1);
    check("dat_oe_low_before", dpl, 0);
    rel_cyc = cyc;
    check("start_bit_drive", ps_dat_oe, 1);

    if (mode == 2) begin
      wait_done(base, int'(FTO) + 50);
      dly = done_cyc - rel_cyc;
      check("first_timeout_window", 32'(dly >= FTO && dly <= FTO + 3), 1);
    end else begin
      repeat (20) @(negedge clock);
      nclk = (mode == 3) ? 5 : 11;
      for (int k = 1; k <= nclk; k++) begin
        if (k == 11 && mode != 1) dev_dat = 1'b0;
        dev_clk  = 1'b0;
        fall_cyc = cyc;
        if (mode == 5 && k == 4) begin
          repeat (10) @(negedge clock);
          reset = 1'b1;
          @(negedge clock);
          reset = 1'b0;
          check("rst_clk_oe", ps_clk_oe, 0);
          check("rst_dat_oe", ps_dat_oe, 0);
          check("rst_busy", busy, 0);
          check("rst_ack_err", {ack_ok, error}, 0);
          dev_clk = 1'b1;
          repeat (200) @(negedge clock);
          check("no_done_after_reset", done_cnt, base);
          return;
        end
        if (mode == 4 && k == 3) begin
          data  = ~d;
          start = 1'b1;
          @(negedge clock);
          start = 1'b0;
          check("busy_during_ignored_start", busy, 1);
        end
        repeat (HALF) @(negedge clock);
        if (k <= 10) got_bits[k-1] = ps_dat_i;
        dev_clk = 1'b1;
        if (k == 11) dev_dat = 1'b1;
        repeat (HALF) @(negedge clock);
      end
      wait_done(base, int'(ETO) + 200);
      if (mode == 3) begin
        dly = done_cyc - fall_cyc;
        check("edge_timeout_window", 32'(dly >= ETO && dly <= ETO + 6), 1);
      end
    end

    check("done_busy", done_busy, 0);
    check("done_oes", {done_clk_oe, done_dat_oe}, 0);
    check("done_ack_ok", done_ack, (mode == 0 || mode == 4) ? 1 : 0);
    check("done_error", done_err, (mode == 0 || mode == 4) ? 0 : 1);
    check("held_ack_ok", ack_ok, done_ack);
    check("held_error", error, done_err);
    if (mode == 0 || mode == 1 || mode == 4) begin
      for (int i = 0; i < 10; i++)
        check($sformatf("frame_bit%0d_d%02h", i, d), got_bits[i], frame_bit(d, i));
    end
  endtask

  initial begin
    repeat (5) @(negedge clock);
    check("reset_busy", busy, 0);
    check("reset_oes", {ps_clk_oe, ps_dat_oe}, 0);
    check("reset_flags", {done, ack_ok, error}, 0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    run_xfer(8'hED, 0);
    run_xfer(8'h01, 0);
    repeat (3) run_xfer(8'($urandom), 0);
    run_xfer(8'($urandom), 1);
    run_xfer(8'hF3, 4);
    run_xfer(8'($urandom), 3);
    run_xfer(8'($urandom), 2);
    run_xfer(8'hFF, 5);
    run_xfer(8'h00, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #10000000;
    $display("FAIL global_timeout: got cycle %0d required completion", cyc);
    $fatal(1, "bench time limit reached");
  end

endmodule
